// File: rtl/correlator_readout_ctrl.sv
// correlator_readout_ctrl: integration counter, bank-swap pulse generator and
// core-major visibility readout streamed out through a 2-entry skid buffer.
// Optional build macro: TART_FRAME_HEADER_EN prepends a frame-number header beat.
module correlator_readout_ctrl #(
   parameter int unsigned ACCUM = 36,
   parameter int unsigned COUNT = 15,
   parameter int unsigned CORES = 18,
   parameter int unsigned WORDS = 32,
   parameter int unsigned ADDR  = 5,
   parameter int unsigned CBITS = 5
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             enable_i,
   input  logic             sample_valid_i,
   output logic             swap_o,
   output logic             rd_en_o,
   output logic [CBITS-1:0] rd_core_o,
   output logic [ADDR-1:0]  rd_addr_o,
   input  logic [ACCUM-1:0] rd_data_i,
   output logic             m_tvalid,
   input  logic             m_tready,
   output logic [ACCUM-1:0] m_tdata,
   output logic             m_tlast,
   output logic             busy_o,
   output logic             overflow_o
);

   typedef enum logic [1:0] {IDLE, READ, DRAIN} state_e;

   state_e            state_q, state_d;
   logic [COUNT-1:0]  cnt_q, cnt_d;
   logic              swap_q, swap_d;
   logic [CBITS-1:0]  core_q, core_d;
   logic [ADDR-1:0]   addr_q, addr_d;
   logic              infl_q, infl_d;
   logic              infl_last_q, infl_last_d;
   logic [1:0]        occ_q, occ_d;
   logic [ACCUM:0]    b0_q, b0_d, b1_q, b1_d;
   logic              ovf_q;
   logic [ACCUM:0]    arr, x0, x1;
   logic [1:0]        n;
   logic              pop, space, last_rd, hdr_slot;
`ifdef TART_FRAME_HEADER_EN
   logic              hdr_pend_q, hdr_pend_d;
   logic              infl_hdr_q, infl_hdr_d;
   logic [15:0]       frame_q;
`endif

   assign swap_o     = swap_q;
   assign rd_core_o  = core_q;
   assign rd_addr_o  = addr_q;
   assign busy_o     = (state_q != IDLE);
   assign overflow_o = ovf_q;

   // Integration counter: wraps on the last sample of a period and requests a swap.
   always_comb begin
      cnt_d  = cnt_q;
      swap_d = 1'b0;
      if (!enable_i) begin
         cnt_d = '0;
      end else if (sample_valid_i) begin
         cnt_d  = cnt_q + 1'b1;
         swap_d = (cnt_q == '1);
      end
   end

   // Output buffer: the in-flight read word bypasses straight to the stream when the
   // buffer is empty, so the first beat appears the cycle its read data returns.
   always_comb begin
      arr = {infl_last_q, rd_data_i};
`ifdef TART_FRAME_HEADER_EN
      if (infl_hdr_q) arr = {1'b0, ACCUM'(frame_q)};
`endif
      n        = occ_q + {1'b0, infl_q};
      x0       = (occ_q != 2'd0) ? b0_q : arr;
      x1       = (occ_q == 2'd2) ? b1_q : arr;
      m_tvalid = (n != 2'd0);
      m_tdata  = m_tvalid ? x0[ACCUM-1:0] : '0;
      m_tlast  = m_tvalid & x0[ACCUM];
      pop      = m_tvalid & m_tready;
      occ_d    = n - {1'b0, pop};
      space    = (occ_d < 2'd2);
      b0_d     = b0_q;
      b1_d     = b1_q;
      if (pop) begin
         b0_d = x1;
      end else begin
         b0_d = x0;
         b1_d = x1;
      end
   end

   // Readout FSM next state, read issue and core-major pointer advance.
   always_comb begin
      state_d     = state_q;
      core_d      = core_q;
      addr_d      = addr_q;
      rd_en_o     = 1'b0;
      infl_d      = 1'b0;
      infl_last_d = 1'b0;
      hdr_slot    = 1'b0;
      last_rd     = (core_q == CBITS'(CORES - 1)) && (addr_q == ADDR'(WORDS - 1));
`ifdef TART_FRAME_HEADER_EN
      hdr_pend_d  = hdr_pend_q;
      infl_hdr_d  = 1'b0;
      hdr_slot    = hdr_pend_q;
`endif
      case (state_q)
         IDLE: begin
            if (swap_q) begin
               state_d = READ;
               core_d  = '0;
               addr_d  = '0;
`ifdef TART_FRAME_HEADER_EN
               hdr_pend_d = 1'b1;
`endif
            end
         end
         READ: begin
            if (space) begin
               infl_d = 1'b1;
               if (hdr_slot) begin
`ifdef TART_FRAME_HEADER_EN
                  // Header takes a read slot so it flows through the same buffer.
                  hdr_pend_d = 1'b0;
                  infl_hdr_d = 1'b1;
`endif
               end else begin
                  rd_en_o     = 1'b1;
                  infl_last_d = last_rd;
                  if (last_rd) begin
                     state_d = DRAIN;
                     core_d  = '0;
                     addr_d  = '0;
                  end else if (addr_q == ADDR'(WORDS - 1)) begin
                     addr_d = '0;
                     core_d = core_q + 1'b1;
                  end else begin
                     addr_d = addr_q + 1'b1;
                  end
               end
            end
         end
         DRAIN: begin
            // Leave as soon as the final beat is consumed, not a cycle later.
            if (occ_d == 2'd0) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // FSM state register.
   always_ff @(posedge clock) begin
      if (!reset_n) state_q <= IDLE;
      else          state_q <= state_d;
   end

   // Datapath registers: counter, swap pulse, pointers, buffer and sticky overflow.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         cnt_q       <= '0;
         swap_q      <= 1'b0;
         core_q      <= '0;
         addr_q      <= '0;
         infl_q      <= 1'b0;
         infl_last_q <= 1'b0;
         occ_q       <= '0;
         b0_q        <= '0;
         b1_q        <= '0;
         ovf_q       <= 1'b0;
`ifdef TART_FRAME_HEADER_EN
         hdr_pend_q  <= 1'b0;
         infl_hdr_q  <= 1'b0;
         frame_q     <= '0;
`endif
      end else begin
         cnt_q       <= cnt_d;
         swap_q      <= swap_d;
         core_q      <= core_d;
         addr_q      <= addr_d;
         infl_q      <= infl_d;
         infl_last_q <= infl_last_d;
         occ_q       <= occ_d;
         b0_q        <= b0_d;
         b1_q        <= b1_d;
         ovf_q       <= ovf_q | (swap_q & (state_q != IDLE));
`ifdef TART_FRAME_HEADER_EN
         hdr_pend_q  <= hdr_pend_d;
         infl_hdr_q  <= infl_hdr_d;
         if (infl_hdr_q) frame_q <= frame_q + 16'd1;
`endif
      end
   end

endmodule

// File: tb/tb_correlator_readout_ctrl.sv
// Scoreboard bench for correlator_readout_ctrl (COUNT=4, CORES=2, WORDS=4).
// Honours TART_FRAME_HEADER_EN when defined for the build.
module tb_correlator_readout_ctrl;

   localparam int unsigned ACCUM = 36;
   localparam int unsigned COUNT = 4;
   localparam int unsigned CORES = 2;
   localparam int unsigned WORDS = 4;
   localparam int unsigned ADDR  = 2;
   localparam int unsigned CBITS = 1;
`ifdef TART_FRAME_HEADER_EN
   localparam int FBEATS = CORES * WORDS + 1;
`else
   localparam int FBEATS = CORES * WORDS;
`endif

   logic             clock = 1'b0;
   logic             reset_n = 1'b0;
   logic             enable_i = 1'b0;
   logic             sample_valid_i = 1'b0;
   logic             swap_o, rd_en_o, m_tvalid, m_tlast, busy_o, overflow_o;
   logic             m_tready = 1'b1;
   logic [CBITS-1:0] rd_core_o;
   logic [ADDR-1:0]  rd_addr_o;
   logic [ACCUM-1:0] rd_data_i = '0;
   logic [ACCUM-1:0] m_tdata;

   correlator_readout_ctrl #(
      .ACCUM(ACCUM), .COUNT(COUNT), .CORES(CORES),
      .WORDS(WORDS), .ADDR(ADDR), .CBITS(CBITS)
   ) dut (
      .clock(clock), .reset_n(reset_n), .enable_i(enable_i),
      .sample_valid_i(sample_valid_i), .swap_o(swap_o), .rd_en_o(rd_en_o),
      .rd_core_o(rd_core_o), .rd_addr_o(rd_addr_o), .rd_data_i(rd_data_i),
      .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tdata(m_tdata),
      .m_tlast(m_tlast), .busy_o(busy_o), .overflow_o(overflow_o)
   );

   always #5 clock = ~clock;

   int cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   // Stub SRAM: {core,addr} one cycle after the strobe, junk otherwise.
   always @(posedge clock) begin
      if (rd_en_o) rd_data_i <= ACCUM'({rd_core_o, 2'b00, rd_addr_o});
      else         rd_data_i <= ACCUM'({$urandom(), $urandom()});
   end

   int pass_cnt = 0;
   int total_cnt = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
   endtask

   // Reference model state.
   logic [ACCUM:0] exp_q[$];
   int             swap_exp[$];
   int             mcnt = 0;
   int             frame_no = 0;
   logic           exp_ovf = 1'b0;

   function automatic void push_frame();
`ifdef TART_FRAME_HEADER_EN
      exp_q.push_back({1'b0, ACCUM'(frame_no % 65536)});
      frame_no++;
`endif
      for (int c = 0; c < int'(CORES); c++)
         for (int a = 0; a < int'(WORDS); a++)
            exp_q.push_back({(c == int'(CORES) - 1 && a == int'(WORDS) - 1) ? 1'b1 : 1'b0,
                             ACCUM'(c * 16 + a)});
   endfunction

   function automatic void model_sample(input bit en);
      if (!en) begin
         mcnt = 0;
      end else begin
         mcnt++;
         if (mcnt == (1 << COUNT)) begin
            mcnt = 0;
            swap_exp.push_back(cyc + 1);
            if (exp_q.size() == 0) push_frame();
            else exp_ovf = 1'b1;
         end
      end
   endfunction

   function automatic void model_reset();
      exp_q.delete();
      swap_exp.delete();
      mcnt = 0;
      frame_no = 0;
      exp_ovf = 1'b0;
   endfunction

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic send(input int n, input bit en);
      for (int i = 0; i < n; i++) begin
         enable_i = en;
         sample_valid_i = 1'b1;
         model_sample(en);
         tick();
      end
      sample_valid_i = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         sample_valid_i = 1'b0;
         if (!enable_i) mcnt = 0;
         tick();
      end
   endtask

   task automatic wait_drain();
      int k = 0;
      while ((exp_q.size() != 0 || busy_o) && k < 400) begin
         tick();
         k++;
      end
      chk("drain_timeout", (k < 400), 1'b1);
      idle(3);
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_swap"}, swap_o, 0);
      chk({tag, "_rd_en"}, rd_en_o, 0);
      chk({tag, "_rd_core"}, rd_core_o, 0);
      chk({tag, "_rd_addr"}, rd_addr_o, 0);
      chk({tag, "_tvalid"}, m_tvalid, 0);
      chk({tag, "_tdata"}, m_tdata, 0);
      chk({tag, "_tlast"}, m_tlast, 0);
      chk({tag, "_busy"}, busy_o, 0);
      chk({tag, "_overflow"}, overflow_o, 0);
   endtask

   // Ready pattern: 0 = always ready, 1 = random 50%, 2 = never ready.
   int rmode = 0;
   initial begin
      forever begin
         @(posedge clock);
         #1;
         case (rmode)
            0:       m_tready = 1'b1;
            1:       m_tready = $urandom_range(0, 1) == 1;
            default: m_tready = 1'b0;
         endcase
      end
   end

   // Monitor: pops expected beats/swaps, checks hold-while-stalled and read throttling.
   logic           stall_prev = 1'b0;
   logic [ACCUM:0] prev_beat = '0;
   int             slots = 0;
   int             beats = 0;
   always @(negedge clock) begin
      if (!reset_n) begin
         stall_prev = 1'b0;
         slots = 0;
         beats = 0;
      end else begin
         if (swap_o) begin
            if (swap_exp.size() == 0) chk("swap_unexpected", swap_o, 0);
            else chk("swap_cycle", cyc, swap_exp.pop_front());
`ifdef TART_FRAME_HEADER_EN
            if (!busy_o) slots++;
`endif
         end
         if (stall_prev)
            chk("stall_hold", {m_tvalid, m_tlast, m_tdata}, {1'b1, prev_beat});
         if (rd_en_o)
            chk("rd_en_space", ((slots - beats - int'(m_tvalid && m_tready)) < 2), 1'b1);
         if (m_tvalid && m_tready) begin
            if (exp_q.size() == 0) begin
               chk("beat_unexpected", {m_tlast, m_tdata}, '1);
            end else begin
               logic [ACCUM:0] e;
               e = exp_q.pop_front();
               chk("beat_data", m_tdata, e[ACCUM-1:0]);
               chk("beat_last", m_tlast, e[ACCUM]);
            end
            beats++;
         end
         if (rd_en_o) slots++;
         stall_prev = m_tvalid && !m_tready;
         prev_beat = {m_tlast, m_tdata};
      end
   end

   initial begin
      #400000;
      $display("FAIL global_timeout: got cycle %0d expected completion", cyc);
      $fatal(1);
   end

   initial begin
      // Reset state.
      enable_i = 1'b1;
      repeat (3) @(posedge clock);
      @(negedge clock);
      chk_reset_outputs("reset");
      @(posedge clock);
      #1;
      reset_n = 1'b1;
      idle(2);

      // One integration: swap timing, stream timing, frame contents.
      rmode = 0;
      send(15, 1);
      enable_i = 1'b1;
      sample_valid_i = 1'b1;
      model_sample(1);
      tick();
      sample_valid_i = 1'b0;
      @(negedge clock);
      chk("swap_pulse", swap_o, 1);
      chk("busy_at_swap", busy_o, 0);
      @(negedge clock);
      chk("busy_start", busy_o, 1);
`ifndef TART_FRAME_HEADER_EN
      chk("rd_en_start", rd_en_o, 1);
`endif
      @(negedge clock);
      chk("first_valid", m_tvalid, 1);
      repeat (FBEATS - 1) @(negedge clock);
      chk("busy_last_beat", busy_o, 1);
      chk("tlast_last_beat", m_tlast, 1);
      @(negedge clock);
      chk("busy_after_frame", busy_o, 0);
      chk("tvalid_after_frame", m_tvalid, 0);
      @(posedge clock);
      #1;
      wait_drain();
      chk("overflow_clean", overflow_o, exp_ovf);

      // Random back-pressure.
      rmode = 1;
      send(16, 1);
      wait_drain();
      rmode = 0;
      send(16, 1);
      rmode = 1;
      wait_drain();

      // Consumer stalled across a second swap: overflow, frame dropped.
      rmode = 2;
      send(16, 1);
      idle(4);
      send(16, 1);
      idle(4);
      chk("overflow_set", overflow_o, exp_ovf);
      chk("busy_stalled", busy_o, 1);
      rmode = 0;
      wait_drain();
      idle(10);
      chk("overflow_sticky", overflow_o, 1);

      // Enable dropped mid-integration restarts the count.
      send(10, 1);
      enable_i = 1'b0;
      idle(3);
      enable_i = 1'b1;
      send(15, 1);
      idle(5);
      send(1, 1);
      wait_drain();

      // Reset mid-frame, then two clean frames.
      rmode = 1;
      send(16, 1);
      idle(5);
      reset_n = 1'b0;
      model_reset();
      tick();
      @(negedge clock);
      chk_reset_outputs("midreset");
      @(posedge clock);
      #1;
      reset_n = 1'b1;
      idle(3);
      rmode = 0;
      send(16, 1);
      wait_drain();
      rmode = 1;
      send(16, 1);
      wait_drain();
      chk("overflow_after_reset", overflow_o, exp_ovf);

      chk("swaps_outstanding", swap_exp.size(), 0);
      chk("beats_outstanding", exp_q.size(), 0);
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule

// File: doc/correlator_readout_ctrl.md
# correlator_readout_ctrl

Sequencer for the TART correlator array. It counts accepted correlator samples and, at the end of each 2^COUNT-sample integration, pulses a bank swap to every correlator core. It then reads the completed visibility bank out of all CORES core SRAMs in core-major order and emits it as an AXI-style stream. It sits between the correlator cores' read ports and the visibility output/host interface.

## Interface

- ACCUM, 36: width of one visibility accumulator word (read data and stream data).
- COUNT, 15: log2 of samples per integration period.
- CORES, 18: number of correlator cores.
- WORDS, 32: visibility words per core bank.
- ADDR, 5: read-address width, equal to log2(WORDS).
- CBITS, 5: core-select width, at least ceil(log2(CORES)).

- clock  in  1  system clock; all logic on the rising edge.
- reset_n  in  1  synchronous, active-low reset.
- enable_i  in  1  run integration counter; low clears counter and suppresses swaps.
- sample_valid_i  in  1  one correlator sample accepted this cycle.
- swap_o  out  1  one-cycle bank-swap pulse to all cores.
- rd_en_o  out  1  SRAM read strobe to the selected core.
- rd_core_o  out  CBITS  core select for the read.
- rd_addr_o  out  ADDR  word address for the read.
- rd_data_i  in  ACCUM  muxed read data, valid exactly 1 cycle after rd_en_o.
- m_tvalid  out  1  stream data valid.
- m_tready  in  1  stream consumer ready.
- m_tdata  out  ACCUM  visibility word.
- m_tlast  out  1  last beat of frame.
- busy_o  out  1  readout FSM not IDLE.
- overflow_o  out  1  sticky: swap occurred while a readout was in progress.

## Operation

- Integration counter: COUNT bits. Increments on sample_valid_i && enable_i. When it is 2^COUNT−1 and a sample is accepted, it wraps to 0, and swap_o is high on the next cycle for one cycle. enable_i low forces the counter to 0 with no swap.
- Readout FSM states: IDLE, READ, DRAIN.
  - IDLE → READ on swap_o; core/address pointers cleared to 0.
  - READ: issue reads core 0 addr 0..WORDS−1, then core 1, …, through core CORES−1 addr WORDS−1. Then → DRAIN.
  - DRAIN → IDLE when no read is in flight and the output buffer is empty.
- Flow control: 2-entry output buffer. rd_en_o is asserted only when (buffer occupancy + reads in flight) < 2, counting a beat popped this cycle. The buffer never overflows and no read data is lost under any m_tready pattern.
- Stream: standard valid/ready. m_tdata/m_tlast are held stable while m_tvalid && !m_tready. m_tlast is set only on the core CORES−1, addr WORDS−1 beat. A frame is CORES*WORDS beats.
- Swap while busy_o: swap_o is still issued (cores must swap), overflow_o is set and held until reset, the current frame completes unchanged, and the new bank is not read (frame dropped).
- enable_i low during readout does not abort the readout.
- Reset: synchronous. It aborts any readout and discards buffer contents.

## Timing

- Reset values: swap_o=0, rd_en_o=0, rd_core_o=0, rd_addr_o=0, m_tvalid=0, m_tdata=0, m_tlast=0, busy_o=0, overflow_o=0. Counter and FSM are cleared to 0/IDLE.
- Final sample accepted at cycle N → swap_o at N+1 → busy_o and first rd_en_o at N+2 → first m_tvalid at N+3.
- With m_tready held high, one beat per cycle; the frame occupies cycles N+3 .. N+2+CORES*WORDS. busy_o drops the cycle after the last beat is accepted.
- Minimum integration period must exceed CORES*WORDS+3 cycles for loss-free operation.

## Configuration

- TART_FRAME_HEADER_EN defined:
  - Each frame begins with one header beat before core 0 addr 0.
  - Header tdata[15:0] is the frame number; upper bits are 0. The frame number starts at 0 after reset and increments per emitted frame, wrapping at 16 bits. Dropped frames do not increment it.
  - A frame is CORES*WORDS+1 beats. ACCUM must be at least 16.
- Undefined: no header; frames are exactly CORES*WORDS beats and there is no frame counter.

## Test plan

All scenarios use COUNT=4, CORES=2, WORDS=4, unless noted. The stub SRAM returns {core,addr}.

- Reset then 16 consecutive samples with enable_i=1 → exactly one swap_o pulse, the cycle after sample 16, and counter back to 0.
- After a swap with m_tready=1 → 8 beats in order 0x0..0x3, 0x10..0x13. m_tlast only on beat 8, busy_o low after it, overflow_o=0.
- m_tready random 50% → same 8 beats, no loss or duplication, tdata stable while stalled, rd_en_o never issued with 2 entries committed.
- m_tready=0 throughout, then a second 16 samples → second swap_o pulses, overflow_o=1 sticky. After releasing m_tready, only the first frame (8 beats) appears.
- enable_i dropped after 10 samples, then raised and 16 samples given → no swap until the 16th post-re-enable sample.
- reset_n low mid-frame → all outputs at reset values on the next cycle, and the next swap produces a clean full frame. With TART_FRAME_HEADER_EN defined, frames are 9 beats with header values 0, 1.
